// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C bus master: START, address+R/W, one data byte, STOP
// Quarter-slot timing engine with slave clock stretching; single master, no arbitration.
module i2c_master #(
    parameter int CLKDIV = 250
) (
    input  logic       CLCK,
    input  logic       RSTN,
    inout  wire        SCL,
    inout  wire        SDA,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ackerr,
    output logic [7:0] rdata
);
    localparam logic [11:0] DIV_LAST = 12'(CLKDIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP
    } state_t;

    state_t      state, state_next;
    logic [11:0] div;
    logic [1:0]  quarter;
    logic [2:0]  bit_cnt;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  addr_byte;
    logic [7:0]  shift;
    logic        ackerr_next;
    logic        scl_s1, scl_s2, sda_s1, sda_s2;
    logic        scl_low, sda_low;
    logic        accept, q_end, slot_end, bit_last;

    assign addr_byte = {addr_q, rw_q};
    assign accept    = (state == IDLE) && start;
    // q2 cannot finish while the slave still holds SCL low
    assign q_end     = (div == DIV_LAST) && !((quarter == 2'd2) && !scl_s2);
    assign slot_end  = q_end && (quarter == 2'd3);
    assign bit_last  = (bit_cnt == 3'd0);

    assign SCL = scl_low ? 1'b0 : 1'bz;
    assign SDA = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLCK or negedge RSTN) begin
        if (!RSTN) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
        end
    end

    always_ff @(posedge CLCK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = START;
            START: if (slot_end) state_next = ADDR;
            ADDR:  if (slot_end && bit_last) state_next = AACK;
            AACK:  if (slot_end) state_next = sda_s2 ? STOP : (rw_q ? RDATA : WDATA);
            WDATA: if (slot_end && bit_last) state_next = WACK;
            WACK:  if (slot_end) state_next = STOP;
            RDATA: if (slot_end && bit_last) state_next = MNACK;
            MNACK: if (slot_end) state_next = STOP;
            STOP:  if (slot_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line drive is decoded from registered state so reset releases both lines at once
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state)
            START: begin
                scl_low = (quarter == 2'd3);
                sda_low = quarter[1];
            end
            ADDR: begin
                scl_low = !quarter[1];
                sda_low = !addr_byte[bit_cnt];
            end
            WDATA: begin
                scl_low = !quarter[1];
                sda_low = !wdata_q[bit_cnt];
            end
            AACK, WACK, RDATA, MNACK: scl_low = !quarter[1];
            STOP: begin
                scl_low = (quarter == 2'd0);
                sda_low = (quarter != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLCK or negedge RSTN) begin
        if (!RSTN) begin
            div         <= 12'd0;
            quarter     <= 2'd0;
            bit_cnt     <= 3'd7;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            wdata_q     <= 8'd0;
            shift       <= 8'd0;
            ackerr_next <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ackerr      <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            done <= 1'b0;
            busy <= (state_next != IDLE);
            if (accept) begin
                div         <= 12'd0;
                quarter     <= 2'd0;
                bit_cnt     <= 3'd7;
                rw_q        <= rw;
                addr_q      <= addr;
                wdata_q     <= wdata;
                ackerr_next <= 1'b0;
            end else if (state != IDLE) begin
                if (q_end) begin
                    div     <= 12'd0;
                    quarter <= quarter + 2'd1;
                end else if (div != DIV_LAST) begin
                    div <= div + 12'd1;
                end
                if (slot_end) begin
                    case (state)
                        ADDR, WDATA: bit_cnt <= bit_cnt - 3'd1;
                        RDATA: begin
                            bit_cnt <= bit_cnt - 3'd1;
                            shift   <= {shift[6:0], sda_s2};
                        end
                        AACK, WACK: if (sda_s2) ackerr_next <= 1'b1;
                        STOP: begin
                            done   <= 1'b1;
                            ackerr <= ackerr_next;
                            if (rw_q && !ackerr_next) rdata <= shift;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a behavioural 7-bit slave
module tb_i2c_master;
    localparam int         CLKDIV     = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h72;
    localparam int         STRETCH    = 50;

    typedef struct {
        int         cyc;
        logic       ackerr;
        logic [7:0] rdata;
        logic [7:0] abyte;
        logic       ack1;
        logic       chk_data;
        logic [7:0] dbyte;
        logic       ack2;
        int         starts;
    } exp_t;

    logic       CLCK = 1'b0;
    logic       RSTN = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ackerr;
    logic [7:0] rdata;
    wire        scl_bus, sda_bus;

    pullup (scl_bus);
    pullup (sda_bus);

    i2c_master #(.CLKDIV(CLKDIV)) dut (
        .CLCK(CLCK), .RSTN(RSTN), .SCL(scl_bus), .SDA(sda_bus),
        .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .ackerr(ackerr), .rdata(rdata)
    );

    always #5 CLCK = ~CLCK;

    int cyc = 0;
    always @(posedge CLCK) cyc <= cyc + 1;

    // Behavioural slave: ACKs SLAVE_ADDR, optionally stretches the first address bit
    logic       scl_hold = 1'b0, sda_hold = 1'b0;
    logic       stretch_en = 1'b0;
    logic [7:0] slave_rbyte = 8'h00;
    logic [7:0] cap_abyte = 8'h00, cap_dbyte = 8'h00;
    logic       cap_ack1 = 1'b0, cap_ack2 = 1'b0;
    logic       scl_prev = 1'b1, sda_prev = 1'b1, scl_now, sda_now;
    int         r = 0, stretch_left = 0, n_start = 0, n_stop = 0;

    assign scl_bus = scl_hold ? 1'b0 : 1'bz;
    assign sda_bus = sda_hold ? 1'b0 : 1'bz;

    always begin
        @(posedge CLCK);
        #1;
        scl_now = scl_bus;
        sda_now = sda_bus;
        if (scl_hold) begin
            if (stretch_left > 0) stretch_left = stretch_left - 1;
            else scl_hold = 1'b0;
        end else begin
            if (scl_now && scl_prev && sda_prev && !sda_now) begin
                n_start = n_start + 1;
                r = 0;
            end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
                n_stop = n_stop + 1;
            end else if (scl_now && !scl_prev) begin
                r = r + 1;
                if (r <= 8) cap_abyte = {cap_abyte[6:0], sda_now};
                if (r == 9) cap_ack1 = sda_now;
                if (r >= 10 && r <= 17) cap_dbyte = {cap_dbyte[6:0], sda_now};
                if (r == 18) cap_ack2 = sda_now;
                if (r == 1 && stretch_en) begin
                    scl_hold = 1'b1;
                    stretch_left = STRETCH;
                end
            end else if (!scl_now && scl_prev) begin
                sda_hold = 1'b0;
                if (r == 8 && cap_abyte[7:1] == SLAVE_ADDR) sda_hold = 1'b1;
                if (r >= 9 && r <= 16 && cap_abyte == {SLAVE_ADDR, 1'b1})
                    sda_hold = !slave_rbyte[3'(16 - r)];
                if (r == 17 && cap_abyte == {SLAVE_ADDR, 1'b0}) sda_hold = 1'b1;
            end
            scl_prev = scl_now;
        end
        sda_prev = sda_now;
    end

    exp_t       sb[$];
    int         n_checks = 0, n_fail = 0;
    int         snap_start = 0, snap_stop = 0;
    logic [7:0] model_rdata = 8'h00;

    task automatic tick();
        @(posedge CLCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int base, input logic r_w, input logic [6:0] a,
                            input logic [7:0] d, input logic [7:0] rb,
                            input int extra, input int starts);
        exp_t e;
        logic nack;
        nack = (a != SLAVE_ADDR);
        if (r_w && !nack) model_rdata = rb;
        e.cyc      = base + (nack ? 44 * CLKDIV + 1 : 80 * CLKDIV + 1) + extra;
        e.ackerr   = nack;
        e.rdata    = model_rdata;
        e.abyte    = {a, r_w};
        e.ack1     = nack;
        e.chk_data = !nack;
        e.dbyte    = r_w ? rb : d;
        e.ack2     = r_w;
        e.starts   = starts;
        sb.push_back(e);
    endtask

    task automatic issue(input logic r_w, input logic [6:0] a, input logic [7:0] d,
                         input logic [7:0] rb, input int extra, input int starts);
        rw = r_w;
        addr = a;
        wdata = d;
        slave_rbyte = rb;
        push_exp(cyc, r_w, a, d, rb, extra, starts);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            seen = done;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", busy, 0);
        check("ackerr", ackerr, e.ackerr);
        check("rdata", rdata, e.rdata);
        check("bus_addr_byte", cap_abyte, e.abyte);
        check("bus_addr_ack", cap_ack1, e.ack1);
        if (e.chk_data) begin
            check("bus_data_byte", cap_dbyte, e.dbyte);
            check("bus_data_ack", cap_ack2, e.ack2);
        end
        check("bus_starts", n_start - snap_start, e.starts);
        check("bus_stops", n_stop - snap_stop, 1);
        snap_start = n_start;
        snap_stop  = n_stop;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        check("rst_scl", scl_bus, 1);
        check("rst_sda", sda_bus, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackerr", ackerr, 0);
        check("rst_rdata", rdata, 8'h00);
        RSTN = 1'b1;
        repeat (2) tick();

        issue(1'b0, 7'h72, 8'h3C, 8'h00, 0, 1);
        check("busy_after_accept", busy, 1);
        wait_done();
        tick();

        issue(1'b1, 7'h72, 8'h00, 8'hA5, 0, 1);
        wait_done();
        tick();

        stretch_en = 1'b1;
        issue(1'b0, 7'h72, 8'hE7, 8'h00, STRETCH, 1);
        wait_done();
        stretch_en = 1'b0;
        tick();

        issue(1'b0, 7'h72, 8'h81, 8'h00, 0, 1);
        repeat (100) tick();
        rw = 1'b1;
        addr = 7'h11;
        wdata = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        expect_quiet("ignored_start_done", 400);

        // Start held high across done: second command is taken in the done cycle
        rw = 1'b0;
        addr = 7'h72;
        wdata = 8'hC5;
        k = cyc;
        push_exp(k, 1'b0, 7'h72, 8'hC5, 8'h00, 0, 1);
        start = 1'b1;
        repeat (20) tick();
        rw = 1'b1;
        wdata = 8'h00;
        slave_rbyte = 8'hC3;
        push_exp(k + 80 * CLKDIV + 1, 1'b1, 7'h72, 8'h00, 8'hC3, 0, 1);
        wait_done();
        tick();
        check("b2b_busy", busy, 1);
        start = 1'b0;
        wait_done();
        tick();

        issue(1'b0, 7'h10, 8'hFF, 8'h00, 0, 1);
        wait_done();
        tick();

        // Abort during WDATA bit 4 (slot 13, q1) with both lines driven low
        rw = 1'b0;
        addr = 7'h72;
        wdata = 8'h0F;
        k = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < k + 13 * 4 * CLKDIV + CLKDIV + 2) tick();
        check("pre_rst_scl", scl_bus, 0);
        check("pre_rst_sda", sda_bus, 0);
        #2;
        RSTN = 1'b0;
        #1;
        check("mid_rst_scl", scl_bus, 1);
        check("mid_rst_sda", sda_bus, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ackerr", ackerr, 0);
        check("mid_rst_rdata", rdata, 8'h00);
        model_rdata = 8'h00;
        repeat (3) tick();
        RSTN = 1'b1;
        expect_quiet("aborted_done", 400);

        issue(1'b0, 7'h72, 8'h96, 8'h00, 0, 2);
        wait_done();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
